// File: rtl/e_mdu_if.sv
// e_mdu_if: E-stage to MDU bus.
// Carries op/operands in and HI/LO/Busy out.
interface e_mdu_if;
    logic        Req;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Req, Op, A, B,
        input  Busy, HI, LO
    );

    modport slave (
        input  Req, Op, A, B,
        output Busy, HI, LO
    );
endinterface

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit.
// Multi-cycle mult/div with fixed latency, owns HI/LO.
module e_mdu (
    input  logic    Clk,
    input  logic    Rst,
    e_mdu_if.slave  mdu
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_CYC = 4'd5;
    localparam logic [3:0] DIV_CYC  = 4'd10;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic        div_zero;

    // Result datapath from latched operands; signed divide via magnitudes
    always_comb begin
        prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u   = {32'd0, a_q} * {32'd0, b_q};
        a_neg    = a_q[31];
        b_neg    = b_q[31];
        a_mag    = a_neg ? (32'd0 - a_q) : a_q;
        b_mag    = b_neg ? (32'd0 - b_q) : b_q;
        div_zero = (b_q == 32'd0);
        q_mag    = 32'd0;
        r_mag    = 32'd0;
        q_u      = 32'd0;
        r_u      = 32'd0;
        if (!div_zero) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
            q_u   = a_q / b_q;
            r_u   = a_q % b_q;
        end
        q_s = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        r_s = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    // Accept/run/complete control and HI/LO next values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            IDLE: begin
                if (!mdu.Req) begin
                    unique case (mdu.Op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            a_d     = mdu.A;
                            b_d     = mdu.B;
                            op_d    = mdu.Op;
                            state_d = RUN;
                            cnt_d   = (mdu.Op == OP_MULT ||
                                       mdu.Op == OP_MULTU)
                                      ? MULT_CYC : DIV_CYC;
                        end
                        OP_MTHI: hi_d = mdu.A;
                        OP_MTLO: lo_d = mdu.A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    unique case (op_q)
                        OP_MULT: begin
                            hi_d = prod_s[63:32];
                            lo_d = prod_s[31:0];
                        end
                        OP_MULTU: begin
                            hi_d = prod_u[63:32];
                            lo_d = prod_u[31:0];
                        end
                        OP_DIV: begin
                            if (!div_zero) begin
                                hi_d = r_s;
                                lo_d = q_s;
                            end
                        end
                        OP_DIVU: begin
                            if (!div_zero) begin
                                hi_d = r_u;
                                lo_d = q_u;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 3'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign mdu.Busy = (state_q == RUN);
    assign mdu.HI   = hi_q;
    assign mdu.LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: randomized scoreboard bench for e_mdu.
// Reference model uses plain 64-bit arithmetic.
module tb_e_mdu;

    logic Clk;
    logic Rst;

    e_mdu_if bus ();

    e_mdu dut (
        .Clk (Clk),
        .Rst (Rst),
        .mdu (bus.slave)
    );

    typedef struct {
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
    } imm_t;

    int          checks = 0;
    int          errors = 0;
    int          ncyc = 0;
    int          run = 0;
    bit          prev_busy = 0;
    bit          abort_pending = 0;
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;
    logic [31:0] hold_hi = 0;
    logic [31:0] hold_lo = 0;
    int          len_q[$];
    logic [63:0] res_q[$];
    imm_t        imm_q[$];

    initial begin
        Clk = 0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Model of HI/LO after a multi-cycle op
    function automatic logic [63:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint sa, sb, p, q, r;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd1: begin
                p = sa * sb;
                return p;
            end
            3'd2: begin
                pu = {32'd0, a} * {32'd0, b};
                return pu;
            end
            3'd3: begin
                if (b == 0) return {hi, lo};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {hi, lo};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic push_imm();
        imm_t e;
        e.due = ncyc + 1;
        e.hi  = m_hi;
        e.lo  = m_lo;
        imm_q.push_back(e);
    endtask

    // Issue one op; req_at>0 pulses Req before that run edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic req,
                         input int req_at, input bit noisy);
        int lat;
        logic [63:0] r;
        hold_hi = m_hi;
        hold_lo = m_lo;
        bus.Op  = op;
        bus.A   = a;
        bus.B   = b;
        bus.Req = req;
        @(posedge Clk);
        #1;
        bus.Op  = 0;
        bus.Req = 0;
        bus.A   = $urandom;
        bus.B   = $urandom;
        if (req || op == 0 || op == 7) begin
            push_imm();
        end else if (op == 5) begin
            m_hi = a;
            push_imm();
        end else if (op == 6) begin
            m_lo = a;
            push_imm();
        end else begin
            lat = (op <= 2) ? 5 : 10;
            r = model(op, a, b, m_hi, m_lo);
            len_q.push_back(lat);
            res_q.push_back(r);
            for (int i = 1; i <= lat; i++) begin
                if (noisy) begin
                    bus.Op  = 3'($urandom_range(0, 7));
                    bus.Req = ($urandom_range(0, 3) == 0);
                    bus.A   = $urandom;
                end
                if (i == req_at) bus.Req = 1;
                @(posedge Clk);
                #1;
                bus.Op  = 0;
                bus.Req = 0;
            end
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
    endtask

    // Monitor: hold checks during Busy, pop results as Busy falls
    always @(negedge Clk) begin
        ncyc++;
        if (bus.Busy) begin
            run++;
            checks++;
            if (bus.HI !== hold_hi || bus.LO !== hold_lo) begin
                errors++;
                $display("FAIL hold: HI=%h LO=%h expected %h %h",
                         bus.HI, bus.LO, hold_hi, hold_lo);
            end
        end else if (prev_busy) begin
            if (len_q.size() == 0) begin
                if (abort_pending) begin
                    abort_pending = 0;
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_busy: ran %0d expected none",
                             run);
                end
            end else begin
                int          l;
                logic [63:0] r;
                l = len_q.pop_front();
                r = res_q.pop_front();
                checks++;
                if (run != l) begin
                    errors++;
                    $display("FAIL busy_len: got %0d expected %0d",
                             run, l);
                end
                checks++;
                if (bus.HI !== r[63:32] || bus.LO !== r[31:0]) begin
                    errors++;
                    $display("FAIL result: HI=%h LO=%h expected %h %h",
                             bus.HI, bus.LO, r[63:32], r[31:0]);
                end
            end
            run = 0;
        end
        while (imm_q.size() > 0 && imm_q[0].due <= ncyc) begin
            imm_t e;
            e = imm_q.pop_front();
            checks++;
            if (bus.Busy !== 1'b0 || bus.HI !== e.hi ||
                bus.LO !== e.lo) begin
                errors++;
                $display("FAIL idle: Busy=%b HI=%h LO=%h expected 0 %h %h",
                         bus.Busy, bus.HI, bus.LO, e.hi, e.lo);
            end
        end
        prev_busy = bus.Busy;
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        req;
        Rst     = 1;
        bus.Req = 0;
        bus.Op  = 0;
        bus.A   = 0;
        bus.B   = 0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 0;
        push_imm();
        @(posedge Clk);
        #1;

        issue(3'd5, 32'h12345678, 32'd0, 0, 0, 0);
        issue(3'd4, 32'd9, 32'd0, 0, 0, 0);
        issue(3'd1, 32'hFFFFFFFD, 32'd7, 0, 0, 0);
        issue(3'd2, 32'hFFFFFFFF, 32'd2, 0, 0, 0);
        issue(3'd3, 32'hFFFFFFF9, 32'd2, 0, 0, 0);
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0);
        issue(3'd1, 32'd1234, 32'd5678, 1, 0, 0);
        issue(3'd4, 32'd100, 32'd7, 0, 2, 0);

        // Reset sampled at E3 of a mult
        hold_hi = m_hi;
        hold_lo = m_lo;
        bus.Op  = 3'd1;
        bus.A   = 32'd77;
        bus.B   = 32'd3;
        @(posedge Clk);
        #1;
        bus.Op = 0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1;
        abort_pending = 1;
        @(posedge Clk);
        #1;
        Rst  = 0;
        m_hi = 0;
        m_lo = 0;
        push_imm();
        @(posedge Clk);
        #1;

        for (int n = 0; n < 80; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 0;
                1: b = $urandom_range(1, 9);
                2: b = 32'hFFFFFFFF;
                default: ;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            req = ($urandom_range(0, 7) == 0);
            issue(op, a, b, req, 0, 1);
        end

        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (len_q.size() != 0 || imm_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending %0d results %0d idle, expected 0",
                     len_q.size(), imm_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
